// File: rtl/cp0_pkg.sv
// cp0_pkg: shared types and constants for the coprocessor-0 move path.
//   cp0_state_e : move sequencer state (IDLE / XFER / WAIT)
//   CP0_OP_*    : single-bit op encoding carried down the E/M stages
//   CP0_REGW    : cp0 register-number width
package cp0_pkg;

  localparam int   CP0_REGW   = 5;
  localparam logic CP0_OP_WR  = 1'b1;
  localparam logic CP0_OP_RD  = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    WAIT = 2'd2
  } cp0_state_e;

endpackage

// File: rtl/cp0_move_ctl_if.sv
// cp0_move_ctl_if: decode, pipeline-control and cp0 handshake signals of the
// cp0 move controller, plus the datapath enables it generates.
//   master : the controller (cp0_move_ctl)
//   slave  : the pipeline / cp0 / datapath side
interface cp0_move_ctl_if;
  import cp0_pkg::*;

  logic                DecMtc0_d;
  logic                DecMfc0_d;
  logic [CP0_REGW-1:0] Cp0Reg_d;
  logic                Stall;
  logic                SquashE;
  logic                SquashM;
  logic                Cp0Ack;

  logic                BenabCop0Latch_s1e;
  logic                BenabCop0Latch_s2e;
  logic                BenabCop0Latch_s1m;
  logic                MvToCop0_s2m;
  logic                cp0BusDrv_s2m;
  logic                Cp0Rd_m;
  logic                Cp0Wr_m;
  logic [CP0_REGW-1:0] Cp0Reg_m;
  logic                Cp0Stall;
  logic                Cp0Timeout;

  modport master (
    input  DecMtc0_d, DecMfc0_d, Cp0Reg_d, Stall, SquashE, SquashM, Cp0Ack,
    output BenabCop0Latch_s1e, BenabCop0Latch_s2e, BenabCop0Latch_s1m,
           MvToCop0_s2m, cp0BusDrv_s2m, Cp0Rd_m, Cp0Wr_m, Cp0Reg_m,
           Cp0Stall, Cp0Timeout
  );

  modport slave (
    output DecMtc0_d, DecMfc0_d, Cp0Reg_d, Stall, SquashE, SquashM, Cp0Ack,
    input  BenabCop0Latch_s1e, BenabCop0Latch_s2e, BenabCop0Latch_s1m,
           MvToCop0_s2m, cp0BusDrv_s2m, Cp0Rd_m, Cp0Wr_m, Cp0Reg_m,
           Cp0Stall, Cp0Timeout
  );

endinterface

// File: rtl/cp0_timeout_ctr.sv
// cp0_timeout_ctr: saturating cycle counter for the cp0 handshake timeout.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (wins over en)
//   en       : count up one, saturating at TIMEOUT
//   hit      : count == TIMEOUT-1 (last waiting cycle before abandon)
module cp0_timeout_ctr #(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic hit
);

  logic [TCW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != TCW'(TIMEOUT)))
      count_d = count_q + TCW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign hit = (count_q == TCW'(TIMEOUT - 1));

endmodule

// File: rtl/cp0_move_ctl.sv
// cp0_move_ctl: sequences MTC0/MFC0 from D through E and M, generates the
// cp0 bus staging-latch and tri-state enables, and runs the Cp0Ack handshake
// with a timeout, stalling the pipeline while cp0 has not answered.
//   Phi1  : clock
//   Reset : synchronous, active-high
//   bus   : decode/pipeline/cp0 inputs and datapath/cp0 outputs
module cp0_move_ctl
  import cp0_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TCW     = 8
) (
  input  logic             Phi1,
  input  logic             Reset,
  cp0_move_ctl_if.master   bus
);

  logic                v_e_q,   v_e_d;
  logic                op_e_q,  op_e_d;
  logic [CP0_REGW-1:0] reg_e_q, reg_e_d;
  logic                v_m_q,   v_m_d;
  logic                op_m_q,  op_m_d;
  logic [CP0_REGW-1:0] reg_m_q, reg_m_d;
  cp0_state_e          state_q, state_d;

  logic act, cnt_hit, timeout_hit, cp0_stall, hold, done, load_m;
  logic ctr_clr, is_wr;

  assign act         = (state_q == XFER) || (state_q == WAIT);
  assign timeout_hit = (state_q == WAIT) && cnt_hit;
  assign cp0_stall   = act && !bus.Cp0Ack && !bus.SquashM && !timeout_hit;
  assign hold        = bus.Stall || cp0_stall;
  // Ack or timeout ends the move; both leave cp0_stall low this cycle.
  assign done        = act && (bus.Cp0Ack || timeout_hit);
  assign load_m      = !hold && v_e_q && !bus.SquashE;
  assign is_wr       = (op_m_q == CP0_OP_WR);

  always_comb begin
    v_e_d   = v_e_q;
    op_e_d  = op_e_q;
    reg_e_d = reg_e_q;
    if (!hold) begin
      v_e_d   = bus.DecMtc0_d || bus.DecMfc0_d;
      op_e_d  = bus.DecMtc0_d ? CP0_OP_WR : CP0_OP_RD;
      reg_e_d = bus.Cp0Reg_d;
    end
    if (bus.SquashE) v_e_d = 1'b0;
  end

  // vM and XFER are loaded on the same edge, so the FSM enters XFER in the
  // first M cycle of the move; a finishing move may hand over directly.
  always_comb begin
    v_m_d   = v_m_q;
    op_m_d  = op_m_q;
    reg_m_d = reg_m_q;
    state_d = state_q;
    if (bus.SquashM) begin
      v_m_d   = 1'b0;
      state_d = IDLE;
    end else if (load_m) begin
      v_m_d   = 1'b1;
      op_m_d  = op_e_q;
      reg_m_d = reg_e_q;
      state_d = XFER;
    end else if (done) begin
      v_m_d   = 1'b0;
      state_d = IDLE;
    end else if (state_q == XFER) begin
      state_d = WAIT;
    end
  end

  assign ctr_clr = bus.SquashM || (state_d == XFER);

  cp0_timeout_ctr #(.TIMEOUT(TIMEOUT), .TCW(TCW)) u_ctr (
    .clk (Phi1),
    .rst (Reset),
    .clr (ctr_clr),
    .en  (act),
    .hit (cnt_hit)
  );

  always_ff @(posedge Phi1) begin
    if (Reset) begin
      v_e_q   <= 1'b0;
      op_e_q  <= CP0_OP_RD;
      reg_e_q <= '0;
      v_m_q   <= 1'b0;
      op_m_q  <= CP0_OP_RD;
      reg_m_q <= '0;
      state_q <= IDLE;
    end else begin
      v_e_q   <= v_e_d;
      op_e_q  <= op_e_d;
      reg_e_q <= reg_e_d;
      v_m_q   <= v_m_d;
      op_m_q  <= op_m_d;
      reg_m_q <= reg_m_d;
      state_q <= state_d;
    end
  end

  assign bus.BenabCop0Latch_s1e = v_e_q && (op_e_q == CP0_OP_WR) && !hold && !bus.SquashE;
  assign bus.BenabCop0Latch_s2e = bus.BenabCop0Latch_s1e;
  assign bus.BenabCop0Latch_s1m = (state_q == XFER) && is_wr;
  assign bus.MvToCop0_s2m       = act && is_wr;
  // Read data is only forwarded to MemBus when the move is not being killed.
  assign bus.cp0BusDrv_s2m      = act && !is_wr && bus.Cp0Ack && !bus.SquashM;
  assign bus.Cp0Wr_m            = act && is_wr;
  assign bus.Cp0Rd_m            = act && !is_wr;
  assign bus.Cp0Reg_m           = act ? reg_m_q : '0;
  assign bus.Cp0Stall           = cp0_stall;
  assign bus.Cp0Timeout         = timeout_hit && !bus.Cp0Ack && !bus.SquashM;

endmodule

// File: tb/tb_cp0_move_ctl.sv
// tb_cp0_move_ctl: directed test-plan scenarios followed by randomized traffic,
// every cycle compared against a transaction-level model of the move path.
module tb_cp0_move_ctl;
  import cp0_pkg::*;

  localparam int TIMEOUT = 16;

  logic Phi1 = 1'b0;
  logic Reset;
  always #5 Phi1 = ~Phi1;

  cp0_move_ctl_if bus ();

  cp0_move_ctl #(.TIMEOUT(TIMEOUT), .TCW(8)) dut (
    .Phi1  (Phi1),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: E slot and M slot hold whole moves; m_age is cycles spent in M.
  bit       e_v, e_wr, m_v, m_wr;
  bit [4:0] e_rg, m_rg;
  int       m_age;
  bit       chk_en;

  // Observed tallies for the directed scenarios.
  int stall_cyc, tmo_cnt, wr_cyc, rd_cyc, drv_cyc, mv_cyc;

  task automatic clr_tally();
    stall_cyc = 0; tmo_cnt = 0; wr_cyc = 0; rd_cyc = 0; drv_cyc = 0; mv_cyc = 0;
  endtask

  task automatic step(input bit mtc, input bit mfc, input bit [4:0] rg,
                      input bit stall, input bit sqe, input bit sqm,
                      input bit ack, input bit rst);
    bit act, xf, hit, cst, hld, e_en, newm;
    logic [8:0] obs, exp;
    @(negedge Phi1);
    bus.DecMtc0_d = mtc; bus.DecMfc0_d = mfc; bus.Cp0Reg_d = rg;
    bus.Stall = stall; bus.SquashE = sqe; bus.SquashM = sqm;
    bus.Cp0Ack = ack; Reset = rst;
    #1;
    act  = m_v;
    xf   = act && (m_age == 0);
    hit  = act && (m_age == TIMEOUT - 1);
    cst  = act && !ack && !sqm && !hit;
    hld  = stall || cst;
    e_en = e_v && e_wr && !hld && !sqe;
    exp  = {e_en, e_en, xf && m_wr, act && m_wr, act && !m_wr && ack && !sqm,
            act && !m_wr, act && m_wr, cst, hit && !ack && !sqm};
    obs  = {bus.BenabCop0Latch_s1e, bus.BenabCop0Latch_s2e, bus.BenabCop0Latch_s1m,
            bus.MvToCop0_s2m, bus.cp0BusDrv_s2m, bus.Cp0Rd_m, bus.Cp0Wr_m,
            bus.Cp0Stall, bus.Cp0Timeout};
    if (chk_en) begin
      chk("outs", 32'(obs), 32'(exp));
      chk("reg_m", 32'(bus.Cp0Reg_m), act ? 32'(m_rg) : 32'd0);
    end
    stall_cyc += int'(bus.Cp0Stall);  tmo_cnt += int'(bus.Cp0Timeout);
    wr_cyc    += int'(bus.Cp0Wr_m);   rd_cyc  += int'(bus.Cp0Rd_m);
    drv_cyc   += int'(bus.cp0BusDrv_s2m); mv_cyc += int'(bus.MvToCop0_s2m);
    if (rst) begin
      e_v = 0; m_v = 0; m_age = 0;
    end else begin
      newm = !hld && e_v && !sqe;
      if (sqm) m_v = 0;
      else if (newm) begin m_v = 1; m_wr = e_wr; m_rg = e_rg; m_age = 0; end
      else if (act && (ack || hit)) m_v = 0;
      else if (act) m_age++;
      if (sqe) e_v = 0;
      else if (!hld) begin e_v = mtc | mfc; e_wr = mtc; e_rg = rg; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic ackc();
    step(0, 0, 5'd0, 0, 0, 0, 1, 0);
  endtask

  initial begin
    bit mtc, mfc, ack, rst, stl, sqe, sqm;
    int r, ack_pct;
    bus.DecMtc0_d = 0; bus.DecMfc0_d = 0; bus.Cp0Reg_d = '0; bus.Stall = 0;
    bus.SquashE = 0; bus.SquashM = 0; bus.Cp0Ack = 0; Reset = 1;
    e_v = 0; e_wr = 0; e_rg = 0; m_v = 0; m_wr = 0; m_rg = 0; m_age = 0;
    chk_en = 0;
    clr_tally();

    // Reset: state is unknown in the first cycle, checked from the second on.
    step(0, 0, 5'd0, 0, 0, 0, 0, 1);
    chk_en = 1;
    step(0, 0, 5'd0, 0, 0, 0, 0, 1);
    idle(2);

    // MTC0 reg 12, acked in XFER.
    clr_tally();
    step(1, 0, 5'd12, 0, 0, 0, 0, 0);
    idle(1);
    ackc();
    idle(2);
    chk("mtc_nostall", 32'(stall_cyc), 32'd0);
    chk("mtc_wr1", 32'(wr_cyc), 32'd1);

    // MFC0 reg 14, acked 3 cycles after XFER.
    clr_tally();
    step(0, 1, 5'd14, 0, 0, 0, 0, 0);
    idle(3);
    idle(1);
    ackc();
    idle(2);
    chk("mfc_stall3", 32'(stall_cyc), 32'd3);
    chk("mfc_drv1", 32'(drv_cyc), 32'd1);
    chk("mfc_nomv", 32'(mv_cyc), 32'd0);

    // MTC0, never acked.
    clr_tally();
    step(1, 0, 5'd7, 0, 0, 0, 0, 0);
    idle(22);
    chk("tmo_stall15", 32'(stall_cyc), 32'd15);
    chk("tmo_pulse1", 32'(tmo_cnt), 32'd1);

    // SquashM with Cp0Ack in WAIT.
    clr_tally();
    step(0, 1, 5'd9, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 5'd0, 0, 0, 1, 1, 0);
    idle(2);
    chk("sqm_nodrv", 32'(drv_cyc), 32'd0);

    // Back-to-back MTC0 then MFC0, each acked in XFER.
    clr_tally();
    step(1, 0, 5'd3, 0, 0, 0, 0, 0);
    step(0, 1, 5'd4, 0, 0, 0, 0, 0);
    ackc();
    ackc();
    idle(2);
    chk("b2b_wr", 32'(wr_cyc), 32'd1);
    chk("b2b_rd", 32'(rd_cyc), 32'd1);
    chk("b2b_nostall", 32'(stall_cyc), 32'd0);

    // Reset mid-WAIT, then SquashE on a move in E.
    step(1, 0, 5'd5, 0, 0, 0, 0, 0);
    idle(3);
    step(0, 0, 5'd0, 0, 0, 0, 0, 1);
    clr_tally();
    idle(2);
    step(1, 0, 5'd6, 0, 0, 0, 0, 0);
    step(0, 0, 5'd0, 0, 1, 0, 0, 0);
    idle(4);
    chk("rst_sqe_nostrobe", 32'(wr_cyc + rd_cyc), 32'd0);

    // Random traffic with phases of frequent and rare acks.
    for (int i = 0; i < 3000; i++) begin
      ack_pct = ((i / 400) % 2 == 0) ? 40 : 3;
      r   = $urandom_range(0, 9);
      mtc = (r < 2);
      mfc = (r == 2 || r == 3);
      stl = ($urandom_range(0, 99) < 10);
      sqe = ($urandom_range(0, 99) < 5);
      sqm = ($urandom_range(0, 99) < 3);
      ack = ($urandom_range(0, 99) < ack_pct);
      rst = ($urandom_range(0, 499) == 0);
      step(mtc, mfc, 5'($urandom_range(0, 31)), stl, sqe, sqm, ack, rst);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
